spi_slave: RTL and testbench

SPI responder (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) for the far end of our SPI master link, used for the board-side loopback and the accelerometer-emulation model. All bus inputs are oversampled in the host clock domain. Received bytes go to an RX FIFO. Transmit bytes come from a TX FIFO; the host-side interface mirrors the master's FIFO interface.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_fifo.sv | 76 +++++++
 rtl/spi_slave.sv | 214 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: frame geometry, FSM encoding, default fill byte.
package spi_pkg;

    localparam int SPI_FRAME_BITS = 8;
    localparam int SPI_CNT_W      = $clog2(SPI_FRAME_BITS);
    localparam logic [SPI_CNT_W-1:0] SPI_LAST_BIT = SPI_CNT_W'(SPI_FRAME_BITS - 1);
    localparam logic [SPI_FRAME_BITS-1:0] SPI_FILL_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } spi_state_e;

    // Bit counter advances modulo the frame length.
    function automatic logic [SPI_CNT_W-1:0] bit_cnt_inc(input logic [SPI_CNT_W-1:0] cnt);
        return cnt + SPI_CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// Small first-word-fall-through FIFO with registered full/empty flags.
module spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push on a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok_s = push & (~full_r | pop);
    assign pop_ok_s  = pop & ~empty_r;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and registered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_MAX);
            empty_r <= (count_next_s == {(AW + 1){1'b0}});
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled bus, 8-bit MSB-first frames, RX/TX FIFOs on the host side.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                        FIFO_DEPTH  = 4,
    parameter logic [SPI_FRAME_BITS-1:0] FILL_BYTE   = SPI_FILL_BYTE,
    parameter int                        SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk_i,
    input  logic                      ncs_i,
    input  logic                      mosi_i,
    output logic                      miso_o,
    output logic                      miso_oe_o,
    input  logic                      enable,
    output logic                      busy,
    input  logic                      rx_read,
    output logic [SPI_FRAME_BITS-1:0] rx_data,
    output logic                      rx_full,
    output logic                      rx_empty,
    output logic                      rx_overrun,
    input  logic                      tx_write,
    input  logic [SPI_FRAME_BITS-1:0] tx_data,
    output logic                      tx_empty,
    output logic                      tx_full,
    output logic                      tx_underrun
);

    logic [SYNC_STAGES-1:0]    sclk_sync_r;
    logic [SYNC_STAGES-1:0]    ncs_sync_r;
    logic [SYNC_STAGES-1:0]    mosi_sync_r;
    logic                      sclk_d_r;
    logic                      ncs_d_r;
    logic                      sclk_s;
    logic                      ncs_s;
    logic                      mosi_s;
    logic                      sclk_rise_s;
    logic                      sclk_fall_s;
    logic                      ncs_fall_s;
    logic                      ncs_rise_s;
    logic                      abort_s;

    spi_state_e                state_r;
    spi_state_e                next_state_s;
    logic [SPI_FRAME_BITS-1:0] shift_tx_r;
    logic [SPI_FRAME_BITS-1:0] shift_tx_next_s;
    logic [SPI_FRAME_BITS-1:0] shift_rx_r;
    logic [SPI_FRAME_BITS-1:0] shift_rx_next_s;
    logic [SPI_CNT_W-1:0]      bit_cnt_r;
    logic [SPI_CNT_W-1:0]      bit_cnt_next_s;
    logic                      byte_done_r;
    logic                      byte_done_next_s;
    logic                      byte_cmpl_s;
    logic                      tx_pop_s;
    logic                      tx_underrun_s;
    logic                      rx_push_s;
    logic                      rx_overrun_s;
    logic [SPI_FRAME_BITS-1:0] tx_head_s;

    logic                      miso_r;
    logic                      miso_oe_r;
    logic                      busy_r;
    logic                      rx_overrun_r;
    logic                      tx_underrun_r;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign ncs_s       = ncs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign ncs_fall_s  = ~ncs_s & ncs_d_r;
    assign ncs_rise_s  = ncs_s & ~ncs_d_r;
    assign abort_s     = ncs_rise_s | ~enable;

    // Bus synchronisers; chip select rests deasserted so reset release is not seen as a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            ncs_sync_r  <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
            ncs_d_r     <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_i};
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs_i};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_i};
            sclk_d_r    <= sclk_s;
            ncs_d_r     <= ncs_s;
        end
    end

    // Next-state and datapath decode; abort wins over any same-cycle SCLK edge.
    always_comb begin
        next_state_s     = state_r;
        shift_tx_next_s  = shift_tx_r;
        shift_rx_next_s  = shift_rx_r;
        bit_cnt_next_s   = bit_cnt_r;
        byte_done_next_s = byte_done_r;
        byte_cmpl_s      = 1'b0;
        tx_pop_s         = 1'b0;
        tx_underrun_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ncs_fall_s && enable) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                bit_cnt_next_s   = {SPI_CNT_W{1'b0}};
                byte_done_next_s = 1'b0;
                if (tx_empty) begin
                    shift_tx_next_s = FILL_BYTE;
                    tx_underrun_s   = 1'b1;
                end else begin
                    shift_tx_next_s = tx_head_s;
                    tx_pop_s        = 1'b1;
                end
                if (abort_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (abort_s) begin
                    next_state_s = ST_IDLE;
                end else if (sclk_rise_s) begin
                    shift_rx_next_s = {shift_rx_r[SPI_FRAME_BITS-2:0], mosi_s};
                    bit_cnt_next_s  = bit_cnt_inc(bit_cnt_r);
                    if (bit_cnt_r == SPI_LAST_BIT) begin
                        byte_cmpl_s      = 1'b1;
                        byte_done_next_s = 1'b1;
                    end else begin
                        byte_cmpl_s      = 1'b0;
                    end
                end else if (sclk_fall_s) begin
                    if (byte_done_r) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        shift_tx_next_s = {shift_tx_r[SPI_FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // A completed byte is dropped unless the RX FIFO has room or frees a slot this cycle.
    assign rx_overrun_s = byte_cmpl_s & rx_full & ~rx_read;
    assign rx_push_s    = byte_cmpl_s & ~rx_overrun_s;

    // State, shifters and registered bus/host outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            shift_tx_r    <= {SPI_FRAME_BITS{1'b0}};
            shift_rx_r    <= {SPI_FRAME_BITS{1'b0}};
            bit_cnt_r     <= {SPI_CNT_W{1'b0}};
            byte_done_r   <= 1'b0;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            busy_r        <= 1'b0;
            rx_overrun_r  <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            shift_tx_r    <= shift_tx_next_s;
            shift_rx_r    <= shift_rx_next_s;
            bit_cnt_r     <= bit_cnt_next_s;
            byte_done_r   <= byte_done_next_s;
            miso_r        <= (next_state_s != ST_IDLE) ? shift_tx_next_s[SPI_FRAME_BITS-1] : 1'b0;
            miso_oe_r     <= (next_state_s != ST_IDLE);
            busy_r        <= (next_state_s != ST_IDLE);
            rx_overrun_r  <= rx_overrun_s;
            tx_underrun_r <= tx_underrun_s;
        end
    end

    spi_fifo #(.WIDTH(SPI_FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_s),
        .wdata (shift_rx_next_s),
        .pop   (rx_read),
        .head  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    spi_fifo #(.WIDTH(SPI_FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_write),
        .wdata (tx_data),
        .pop   (tx_pop_s),
        .head  (tx_head_s),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign miso_o      = miso_r;
    assign miso_oe_o   = miso_oe_r;
    assign busy        = busy_r;
    assign rx_overrun  = rx_overrun_r;
    assign tx_underrun = tx_underrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged mode-0 master with hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_i, ncs_i, mosi_i;
    logic       miso_o, miso_oe_o;
    logic       enable, busy;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_full, rx_empty, rx_overrun;
    logic       tx_write;
    logic [7:0] tx_data;
    logic       tx_empty, tx_full, tx_underrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int und_cnt      = 0;
    int ovr_cnt      = 0;

    spi_slave #(.FIFO_DEPTH(4), .FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst_n), .sclk_i(sclk_i), .ncs_i(ncs_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .enable(enable), .busy(busy),
        .rx_read(rx_read), .rx_data(rx_data), .rx_full(rx_full), .rx_empty(rx_empty),
        .rx_overrun(rx_overrun), .tx_write(tx_write), .tx_data(tx_data),
        .tx_empty(tx_empty), .tx_full(tx_full), .tx_underrun(tx_underrun)
    );

    // Host clock.
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_underrun) und_cnt <= und_cnt + 1;
        if (rx_overrun)  ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data = b; tx_write = 1'b1;
        wait_clk(1);
        tx_write = 1'b0;
        wait_clk(1);
    endtask

    task automatic pop_rx(output logic [7:0] b);
        b = rx_data; rx_read = 1'b1;
        wait_clk(1);
        rx_read = 1'b0;
        wait_clk(1);
    endtask

    // Shifts nbits MSB-first; on the last bit of a frame ncs rises together with the final fall.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit last, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi_i = mo[i];
            wait_clk(H);
            mi[i] = miso_o;
            sclk_i = 1'b1;
            wait_clk(H);
            sclk_i = 1'b0;
            if (last && i == 0) ncs_i = 1'b1;
        end
    endtask

    task automatic frame1(input logic [7:0] mo, output logic [7:0] mi);
        ncs_i = 1'b0;
        wait_clk(H);
        spi_xfer(mo, 8, 1'b1, mi);
        wait_clk(2 * H);
    endtask

    initial begin
        logic [7:0] mi, got;
        int u0, o0;
        rst_n = 1'b0; sclk_i = 1'b0; ncs_i = 1'b1; mosi_i = 1'b0; enable = 1'b0;
        rx_read = 1'b0; tx_write = 1'b0; tx_data = 8'h00;
        wait_clk(3);
        check_eq("reset_flags", 32'({miso_o, miso_oe_o, busy, rx_empty, tx_empty, rx_full, tx_full, rx_overrun, tx_underrun}), 32'h30);
        check_eq("reset_rx_data", 32'(rx_data), 32'h00);
        rst_n = 1'b1; enable = 1'b1;
        wait_clk(2);

        // Reset mid-frame, then a clean frame.
        push_tx(8'hAA); push_tx(8'hAB);
        ncs_i = 1'b0; wait_clk(H);
        spi_xfer(8'hF0, 3, 1'b0, mi);
        check_eq("mid_busy", 32'(busy), 32'h1);
        check_eq("mid_tx_empty", 32'(tx_empty), 32'h0);
        rst_n = 1'b0; #1;
        check_eq("mid_reset_flags", 32'({miso_o, miso_oe_o, busy, rx_empty, tx_empty, rx_full, tx_full, rx_overrun, tx_underrun}), 32'h30);
        ncs_i = 1'b1; wait_clk(2); rst_n = 1'b1; wait_clk(4);
        frame1(8'h5A, mi);
        check_eq("after_rst_miso", 32'(mi), 32'hFF);
        check_eq("after_rst_rx_empty", 32'(rx_empty), 32'h0);
        pop_rx(got);
        check_eq("after_rst_rx", 32'(got), 32'h5A);

        // Single frame.
        push_tx(8'hC3);
        u0 = und_cnt; o0 = ovr_cnt;
        frame1(8'hA5, mi);
        check_eq("single_miso", 32'(mi), 32'hC3);
        check_eq("single_rx_data", 32'(rx_data), 32'hA5);
        check_eq("single_rx_empty", 32'(rx_empty), 32'h0);
        check_eq("single_tx_empty", 32'(tx_empty), 32'h1);
        check_eq("single_pulses", 32'(und_cnt - u0 + ovr_cnt - o0), 32'h0);
        pop_rx(got);
        check_eq("single_rx_empty_after_pop", 32'(rx_empty), 32'h1);

        // Back-to-back frames with ncs held low.
        push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
        ncs_i = 1'b0; wait_clk(H);
        for (int i = 0; i < 3; i++) begin
            spi_xfer(8'((i + 1) * 16), 8, (i == 2), mi);
            check_eq("b2b_miso", 32'(mi), 32'(i + 1));
        end
        wait_clk(2 * H);
        for (int i = 0; i < 3; i++) begin
            pop_rx(got);
            check_eq("b2b_rx", 32'(got), 32'((i + 1) * 16));
        end

        // Underrun.
        u0 = und_cnt;
        frame1(8'h77, mi);
        check_eq("und_miso", 32'(mi), 32'hFF);
        check_eq("und_pulses", 32'(und_cnt - u0), 32'h1);
        check_eq("und_rx_data", 32'(rx_data), 32'h77);
        pop_rx(got);

        // Overrun: five bytes into a four-deep RX FIFO.
        o0 = ovr_cnt;
        ncs_i = 1'b0; wait_clk(H);
        for (int i = 0; i < 5; i++) begin
            spi_xfer(8'(i), 8, (i == 4), mi);
            if (i == 3) check_eq("ovr_before_last", 32'(ovr_cnt - o0), 32'h0);
        end
        wait_clk(2 * H);
        check_eq("ovr_pulses", 32'(ovr_cnt - o0), 32'h1);
        check_eq("ovr_rx_full", 32'(rx_full), 32'h1);
        for (int i = 0; i < 4; i++) begin
            pop_rx(got);
            check_eq("ovr_rx", 32'(got), 32'(i));
        end
        check_eq("ovr_rx_empty", 32'(rx_empty), 32'h1);

        // Abort after five SCLK edges.
        push_tx(8'h3C);
        ncs_i = 1'b0; wait_clk(H);
        spi_xfer(8'hFF, 2, 1'b0, mi);
        mosi_i = 1'b1; wait_clk(H);
        sclk_i = 1'b1; wait_clk(H);
        check_eq("abort_busy_before", 32'(busy), 32'h1);
        ncs_i = 1'b1;
        wait_clk(4);
        check_eq("abort_busy_after", 32'(busy), 32'h0);
        check_eq("abort_oe_after", 32'(miso_oe_o), 32'h0);
        sclk_i = 1'b0; wait_clk(2 * H);
        check_eq("abort_rx_empty", 32'(rx_empty), 32'h1);
        check_eq("abort_tx_empty", 32'(tx_empty), 32'h1);
        frame1(8'h11, mi);
        check_eq("abort_next_miso", 32'(mi), 32'hFF);
        pop_rx(got);
        check_eq("abort_next_rx", 32'(got), 32'h11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
